// File: rtl/rename_regfile_if.sv
// rtl/rename_regfile_if.sv - decode, commit and dispatch bundle for rename_regfile
interface rename_regfile_if #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int TAG_W   = 4,
  parameter int NCOMMIT = 2
);
  localparam int RW = $clog2(NREG);

  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [RW-1:0]            in_rs1;
  logic [RW-1:0]            in_rs2;
  logic [RW-1:0]            in_rd;
  logic                     in_rd_wen;
  logic [TAG_W-1:0]         rob_tail;
  logic [NCOMMIT-1:0]       cm_valid;
  logic [NCOMMIT*RW-1:0]    cm_addr;
  logic [NCOMMIT*TAG_W-1:0] cm_tag;
  logic [NCOMMIT*XLEN-1:0]  cm_value;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_vj;
  logic [XLEN-1:0]          out_vk;
  logic                     out_qj_busy;
  logic                     out_qk_busy;
  logic [TAG_W-1:0]         out_qj;
  logic [TAG_W-1:0]         out_qk;

  // Decoder / ROB / dispatch side
  modport master (
    output flush, in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, rob_tail,
           cm_valid, cm_addr, cm_tag, cm_value, out_ready,
    input  in_ready, out_valid, out_vj, out_vk, out_qj_busy, out_qk_busy,
           out_qj, out_qk
  );

  // Register file side
  modport slave (
    input  flush, in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, rob_tail,
           cm_valid, cm_addr, cm_tag, cm_value, out_ready,
    output in_ready, out_valid, out_vj, out_vk, out_qj_busy, out_qk_busy,
           out_qj, out_qk
  );
endinterface

// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - architectural register file with rename tags and operand output stage
module rename_regfile #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int TAG_W   = 4,
  parameter int NCOMMIT = 2
) (
  input logic             clk,
  input logic             clr,
  rename_regfile_if.slave bus
);
  localparam int RW = $clog2(NREG);

  logic [XLEN-1:0]  value_q [NREG];
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [NREG-1:0]  busy_q;

  logic             out_valid_q;
  logic [XLEN-1:0]  out_vj_q, out_vk_q;
  logic             out_qj_busy_q, out_qk_busy_q;
  logic [TAG_W-1:0] out_qj_q, out_qk_q;

  logic             accept;
  logic             do_rename;
  logic [RW-1:0]    src   [2];
  logic [XLEN-1:0]  src_v [2];
  logic             src_b [2];
  logic [TAG_W-1:0] src_t [2];

  assign bus.in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign do_rename    = accept && bus.in_rd_wen && (bus.in_rd != '0);
  assign src[0]       = bus.in_rs1;
  assign src[1]       = bus.in_rs2;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_vj      = out_vj_q;
  assign bus.out_vk      = out_vk_q;
  assign bus.out_qj_busy = out_qj_busy_q;
  assign bus.out_qk_busy = out_qk_busy_q;
  assign bus.out_qj      = out_qj_q;
  assign bus.out_qk      = out_qk_q;

  // Resolve both sources against pre-rename state, forwarding a same-cycle commit of the awaited tag
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_v[s] = '0;
      src_b[s] = 1'b0;
      src_t[s] = '0;
      if (src[s] != '0) begin
        if (busy_q[src[s]]) begin
          src_b[s] = 1'b1;
          src_t[s] = tag_q[src[s]];
          for (int p = 0; p < NCOMMIT; p++) begin
            if (bus.cm_valid[p] && bus.cm_addr[p*RW +: RW] == src[s] &&
                bus.cm_tag[p*TAG_W +: TAG_W] == tag_q[src[s]]) begin
              src_v[s] = bus.cm_value[p*XLEN +: XLEN];
              src_b[s] = 1'b0;
              src_t[s] = '0;
            end
          end
        end else begin
          src_v[s] = value_q[src[s]];
        end
      end
    end
  end

  // Register file: commits write values, a same-cycle rename wins busy/tag, flush drops all tags
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int r = 0; r < NREG; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
      busy_q <= '0;
    end else begin
      // later ports overwrite earlier ones, so the youngest commit owns the value
      for (int p = 0; p < NCOMMIT; p++) begin
        if (bus.cm_valid[p]) begin
          if (bus.cm_addr[p*RW +: RW] != '0)
            value_q[bus.cm_addr[p*RW +: RW]] <= bus.cm_value[p*XLEN +: XLEN];
          if (tag_q[bus.cm_addr[p*RW +: RW]] == bus.cm_tag[p*TAG_W +: TAG_W] &&
              !(do_rename && bus.in_rd == bus.cm_addr[p*RW +: RW]))
            busy_q[bus.cm_addr[p*RW +: RW]] <= 1'b0;
        end
      end
      if (do_rename) begin
        busy_q[bus.in_rd] <= 1'b1;
        tag_q[bus.in_rd]  <= bus.rob_tail;
      end
      if (bus.flush)
        busy_q <= '0;
    end
  end

  // Output stage: load on accept, drain on ready, wake waiting operands by tag while stalled
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_valid_q   <= 1'b0;
      out_vj_q      <= '0;
      out_vk_q      <= '0;
      out_qj_busy_q <= 1'b0;
      out_qk_busy_q <= 1'b0;
      out_qj_q      <= '0;
      out_qk_q      <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      out_vj_q      <= src_v[0];
      out_vk_q      <= src_v[1];
      out_qj_busy_q <= src_b[0];
      out_qk_busy_q <= src_b[1];
      out_qj_q      <= src_t[0];
      out_qk_q      <= src_t[1];
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end else if (out_valid_q) begin
      for (int p = 0; p < NCOMMIT; p++) begin
        if (bus.cm_valid[p] && out_qj_busy_q && bus.cm_tag[p*TAG_W +: TAG_W] == out_qj_q) begin
          out_vj_q      <= bus.cm_value[p*XLEN +: XLEN];
          out_qj_busy_q <= 1'b0;
        end
        if (bus.cm_valid[p] && out_qk_busy_q && bus.cm_tag[p*TAG_W +: TAG_W] == out_qk_q) begin
          out_vk_q      <= bus.cm_value[p*XLEN +: XLEN];
          out_qk_busy_q <= 1'b0;
        end
      end
    end
  end
endmodule
